// File: rtl/prf_param_restore_if.sv
// prf_param_restore_if
//   Bundles every non-clock signal of the physical register file so that
//   rename/dispatch, issue and writeback can be wired as one bus.
//   master : the surrounding core (drives strobes, tags, data, arch value)
//   slave  : the register file (returns read data, ready, restore status)
//   Signals:
//     alloc_en/alloc_tag    rename allocation (clears ready)
//     wb_en/wb_tag/wb_data  NUM_WB packed writeback ports
//     rd_tag/rd_data        NUM_RD packed issue read ports
//     rn_tag/rn_data/rn_ready NUM_RN packed rename read ports
//     flush_req             exception/mret pulse, starts restore walk
//     arch_idx/arch_data    architectural file lookup during the walk
//     busy/restore_done     walk status
interface prf_param_restore_if #(
  parameter int XLEN      = 32,
  parameter int NUM_PREGS = 256,
  parameter int ARCH_REGS = 32,
  parameter int NUM_WB    = 7,
  parameter int NUM_RD    = 11,
  parameter int NUM_RN    = 2
);
  localparam int TAGW = $clog2(NUM_PREGS);
  localparam int AW   = $clog2(ARCH_REGS);

  logic                     alloc_en;
  logic [TAGW-1:0]          alloc_tag;
  logic [NUM_WB-1:0]        wb_en;
  logic [NUM_WB*TAGW-1:0]   wb_tag;
  logic [NUM_WB*XLEN-1:0]   wb_data;
  logic [NUM_RD*TAGW-1:0]   rd_tag;
  logic [NUM_RD*XLEN-1:0]   rd_data;
  logic [NUM_RN*TAGW-1:0]   rn_tag;
  logic [NUM_RN*XLEN-1:0]   rn_data;
  logic [NUM_RN-1:0]        rn_ready;
  logic                     flush_req;
  logic [AW-1:0]            arch_idx;
  logic [XLEN-1:0]          arch_data;
  logic                     busy;
  logic                     restore_done;

  modport master (
    output alloc_en, alloc_tag, wb_en, wb_tag, wb_data, rd_tag, rn_tag,
           flush_req, arch_data,
    input  rd_data, rn_data, rn_ready, arch_idx, busy, restore_done
  );

  modport slave (
    input  alloc_en, alloc_tag, wb_en, wb_tag, wb_data, rd_tag, rn_tag,
           flush_req, arch_data,
    output rd_data, rn_data, rn_ready, arch_idx, busy, restore_done
  );
endinterface

// File: rtl/prf_param_restore.sv
// prf_param_restore
//   Physical register file with per-entry ready scoreboard and a multi-cycle
//   restore walk that copies the architectural file into entries
//   0..ARCH_REGS-1 after an exception or mret.
//   Ports:
//     clk    clock
//     reset  synchronous, active-high
//     bus    prf_param_restore_if.slave (writeback, alloc, read, restore)
//   Optional build macro: PRF_BYPASS_EN -- same-cycle writeback data and
//   ready are forwarded to the read ports while idle.
//   Tag 0 is hardwired: never written outside the walk (which writes 0),
//   never allocated, so it always reads 0 / ready.

// One read lane: array value, optionally overridden by a same-cycle writeback.
module prf_param_restore_rdlane #(
  parameter int XLEN   = 32,
  parameter int TAGW   = 8,
  parameter int NUM_WB = 7
) (
  input  logic [TAGW-1:0]              i_tag,
  input  logic [XLEN-1:0]              i_arr_data,
  input  logic                         i_arr_ready,
  input  logic                         i_byp_en,
  input  logic [NUM_WB-1:0]            i_wb_en,
  input  logic [NUM_WB-1:0][TAGW-1:0]  i_wb_tag,
  input  logic [NUM_WB-1:0][XLEN-1:0]  i_wb_data,
  input  logic                         i_alloc_en,
  input  logic [TAGW-1:0]              i_alloc_tag,
  output logic [XLEN-1:0]              o_data,
  output logic                         o_ready
);
`ifdef PRF_BYPASS_EN
  // Ascending scan so the highest matching port is the one that sticks,
  // mirroring the array write priority.
  always_comb begin
    o_data  = i_arr_data;
    o_ready = i_arr_ready;
    if (i_byp_en && i_tag != '0) begin
      for (int k = 0; k < NUM_WB; k++) begin
        if (i_wb_en[k] && i_wb_tag[k] == i_tag) begin
          o_data  = i_wb_data[k];
          o_ready = !(i_alloc_en && i_alloc_tag == i_tag);
        end
      end
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{i_tag, i_byp_en, i_wb_en, i_wb_tag, i_wb_data,
                      i_alloc_en, i_alloc_tag};
  assign o_data  = i_arr_data;
  assign o_ready = i_arr_ready;
`endif
endmodule

module prf_param_restore #(
  parameter int XLEN      = 32,
  parameter int NUM_PREGS = 256,
  parameter int ARCH_REGS = 32,
  parameter int NUM_WB    = 7,
  parameter int NUM_RD    = 11,
  parameter int NUM_RN    = 2
) (
  input  logic               clk,
  input  logic               reset,
  prf_param_restore_if.slave bus
);
  localparam int TAGW = $clog2(NUM_PREGS);
  localparam int AW   = $clog2(ARCH_REGS);

  typedef enum logic {S_IDLE, S_RESTORE} state_t;

  state_t                r_state;
  logic [XLEN-1:0]       r_mem [NUM_PREGS];
  logic [NUM_PREGS-1:0]  r_ready;
  logic [AW-1:0]         r_idx;
  logic                  r_busy;
  logic                  r_done;

  // Unpacked views of the flat bus vectors.
  logic [NUM_WB-1:0]            w_wb_en;
  logic [NUM_WB-1:0][TAGW-1:0]  w_wb_tag;
  logic [NUM_WB-1:0][XLEN-1:0]  w_wb_data;
  logic [NUM_RD-1:0][TAGW-1:0]  w_rd_tag;
  logic [NUM_RD-1:0][XLEN-1:0]  w_rd_data;
  logic [NUM_RD-1:0]            w_rd_ready_unused;
  logic [NUM_RN-1:0][TAGW-1:0]  w_rn_tag;
  logic [NUM_RN-1:0][XLEN-1:0]  w_rn_data;
  logic [NUM_RN-1:0]            w_rn_ready;
  logic                         w_byp_en;

  assign w_wb_en   = bus.wb_en;
  assign w_wb_tag  = bus.wb_tag;
  assign w_wb_data = bus.wb_data;
  assign w_rd_tag  = bus.rd_tag;
  assign w_rn_tag  = bus.rn_tag;

  // Forwarding only when the writeback will actually land this edge.
  assign w_byp_en = (r_state == S_IDLE) && !bus.flush_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PREGS; i++)
        r_mem[i] <= (i < ARCH_REGS) ? XLEN'(i) : '0;
      r_ready <= '1;
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (bus.flush_req) begin
      // Start (or restart) the walk; wb/alloc on this edge are dropped.
      r_ready <= '1;
      r_state <= S_RESTORE;
      r_idx   <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Later ports overwrite earlier ones: highest index wins.
          for (int k = 0; k < NUM_WB; k++) begin
            if (w_wb_en[k] && w_wb_tag[k] != '0) begin
              r_mem[w_wb_tag[k]]   <= w_wb_data[k];
              r_ready[w_wb_tag[k]] <= 1'b1;
            end
          end
          // After the wb loop so alloc wins on a shared tag.
          if (bus.alloc_en && bus.alloc_tag != '0)
            r_ready[bus.alloc_tag] <= 1'b0;
        end
        S_RESTORE: begin
          r_mem[TAGW'(r_idx)] <= (r_idx == '0) ? '0 : bus.arch_data;
          r_idx <= r_idx + 1'b1;
          if (r_idx == AW'(ARCH_REGS-1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end else begin
            // Registered early so the pulse lines up with the last write.
            r_done <= (r_idx == AW'(ARCH_REGS-2));
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.arch_idx     = r_idx;
  assign bus.busy         = r_busy;
  // A flush on the final cycle aborts that walk's last write, so no pulse.
  assign bus.restore_done = r_done && !bus.flush_req;

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    prf_param_restore_rdlane #(.XLEN(XLEN), .TAGW(TAGW), .NUM_WB(NUM_WB)) u_lane (
      .i_tag       (w_rd_tag[j]),
      .i_arr_data  (r_mem[w_rd_tag[j]]),
      .i_arr_ready (r_ready[w_rd_tag[j]]),
      .i_byp_en    (w_byp_en),
      .i_wb_en     (w_wb_en),
      .i_wb_tag    (w_wb_tag),
      .i_wb_data   (w_wb_data),
      .i_alloc_en  (bus.alloc_en),
      .i_alloc_tag (bus.alloc_tag),
      .o_data      (w_rd_data[j]),
      .o_ready     (w_rd_ready_unused[j])
    );
  end

  for (genvar j = 0; j < NUM_RN; j++) begin : g_rn
    prf_param_restore_rdlane #(.XLEN(XLEN), .TAGW(TAGW), .NUM_WB(NUM_WB)) u_lane (
      .i_tag       (w_rn_tag[j]),
      .i_arr_data  (r_mem[w_rn_tag[j]]),
      .i_arr_ready (r_ready[w_rn_tag[j]]),
      .i_byp_en    (w_byp_en),
      .i_wb_en     (w_wb_en),
      .i_wb_tag    (w_wb_tag),
      .i_wb_data   (w_wb_data),
      .i_alloc_en  (bus.alloc_en),
      .i_alloc_tag (bus.alloc_tag),
      .o_data      (w_rn_data[j]),
      .o_ready     (w_rn_ready[j])
    );
  end

  assign bus.rd_data  = w_rd_data;
  assign bus.rn_data  = w_rn_data;
  assign bus.rn_ready = w_rn_ready;
endmodule

// File: tb/tb_prf_param_restore.sv
// tb_prf_param_restore
//   Scoreboard bench: each stimulus cycle pushes the expected outputs
//   (from an array-based reference model) into a queue; a negedge monitor
//   pops and compares against the DUT.
module tb_prf_param_restore;
  localparam int XLEN = 32, NUM_PREGS = 256, ARCH_REGS = 32;
  localparam int NUM_WB = 7, NUM_RD = 11, NUM_RN = 2;
  localparam int TAGW = $clog2(NUM_PREGS);
  localparam int AW   = $clog2(ARCH_REGS);
`ifdef PRF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  prf_param_restore_if #(.XLEN(XLEN), .NUM_PREGS(NUM_PREGS), .ARCH_REGS(ARCH_REGS),
    .NUM_WB(NUM_WB), .NUM_RD(NUM_RD), .NUM_RN(NUM_RN)) bus ();

  prf_param_restore #(.XLEN(XLEN), .NUM_PREGS(NUM_PREGS), .ARCH_REGS(ARCH_REGS),
    .NUM_WB(NUM_WB), .NUM_RD(NUM_RD), .NUM_RN(NUM_RN)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  // Architectural file, looked up combinationally by the DUT.
  logic [XLEN-1:0] arch_file [ARCH_REGS];
  assign bus.arch_data = arch_file[bus.arch_idx];

  // Reference model
  logic [XLEN-1:0] m_mem [NUM_PREGS];
  bit              m_rdy [NUM_PREGS];
  int              m_left;   // restore cycles remaining; 0 = idle

  // Stimulus for the current cycle
  bit              s_rst, s_flush, s_alloc_en;
  int              s_alloc_tag;
  bit              s_wb_en  [NUM_WB];
  int              s_wb_tag [NUM_WB];
  logic [XLEN-1:0] s_wb_data[NUM_WB];
  int              s_rd_tag [NUM_RD];
  int              s_rn_tag [NUM_RN];

  typedef struct packed {
    logic [NUM_RD-1:0][XLEN-1:0] rd;
    logic [NUM_RN-1:0][XLEN-1:0] rn;
    logic [NUM_RN-1:0]           rnr;
    logic                        busy;
    logic                        done;
    logic                        idx_chk;
    logic [AW-1:0]               idx;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int i, input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] t=%0t got=%h want=%h", nm, i, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int j = 0; j < NUM_RD; j++)
        chk("rd_data", j, bus.rd_data[j*XLEN +: XLEN], e.rd[j]);
      for (int j = 0; j < NUM_RN; j++) begin
        chk("rn_data", j, bus.rn_data[j*XLEN +: XLEN], e.rn[j]);
        chk("rn_ready", j, XLEN'(bus.rn_ready[j]), XLEN'(e.rnr[j]));
      end
      chk("busy", 0, XLEN'(bus.busy), XLEN'(e.busy));
      chk("restore_done", 0, XLEN'(bus.restore_done), XLEN'(e.done));
      if (e.idx_chk) chk("arch_idx", 0, XLEN'(bus.arch_idx), XLEN'(e.idx));
    end
  end

  function automatic void byp(input int t, inout logic [XLEN-1:0] d, output bit h);
    h = 1'b0;
    if (BYP && m_left == 0 && !s_flush && t != 0)
      for (int k = 0; k < NUM_WB; k++)
        if (s_wb_en[k] && s_wb_tag[k] == t) begin d = s_wb_data[k]; h = 1'b1; end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    logic [XLEN-1:0] d;
    bit h;
    for (int j = 0; j < NUM_RD; j++) begin
      d = m_mem[s_rd_tag[j]]; byp(s_rd_tag[j], d, h); e.rd[j] = d;
    end
    for (int j = 0; j < NUM_RN; j++) begin
      d = m_mem[s_rn_tag[j]]; byp(s_rn_tag[j], d, h); e.rn[j] = d;
      e.rnr[j] = h ? !(s_alloc_en && s_alloc_tag == s_rn_tag[j]) : m_rdy[s_rn_tag[j]];
    end
    e.busy    = (m_left > 0);
    e.done    = (m_left == 1) && !s_flush;
    e.idx_chk = (m_left > 0);
    e.idx     = AW'(ARCH_REGS - m_left);
    return e;
  endfunction

  // Effect of one clock edge on the model, using the inputs of the cycle.
  task automatic model_edge();
    if (s_rst) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        m_mem[i] = (i < ARCH_REGS) ? XLEN'(i) : '0;
        m_rdy[i] = 1'b1;
      end
      m_left = 0;
    end else if (s_flush) begin
      for (int i = 0; i < NUM_PREGS; i++) m_rdy[i] = 1'b1;
      m_left = ARCH_REGS;
    end else if (m_left > 0) begin
      int w;
      w = ARCH_REGS - m_left;
      m_mem[w] = (w == 0) ? '0 : arch_file[w];
      m_left--;
    end else begin
      for (int k = 0; k < NUM_WB; k++)
        if (s_wb_en[k] && s_wb_tag[k] != 0) begin
          m_mem[s_wb_tag[k]] = s_wb_data[k];
          m_rdy[s_wb_tag[k]] = 1'b1;
        end
      if (s_alloc_en && s_alloc_tag != 0) m_rdy[s_alloc_tag] = 1'b0;
    end
  endtask

  task automatic drive();
    reset         = s_rst;
    bus.flush_req = s_flush;
    bus.alloc_en  = s_alloc_en;
    bus.alloc_tag = TAGW'(s_alloc_tag);
    for (int k = 0; k < NUM_WB; k++) begin
      bus.wb_en[k] = s_wb_en[k];
      bus.wb_tag[k*TAGW +: TAGW]  = TAGW'(s_wb_tag[k]);
      bus.wb_data[k*XLEN +: XLEN] = s_wb_data[k];
    end
    for (int j = 0; j < NUM_RD; j++) bus.rd_tag[j*TAGW +: TAGW] = TAGW'(s_rd_tag[j]);
    for (int j = 0; j < NUM_RN; j++) bus.rn_tag[j*TAGW +: TAGW] = TAGW'(s_rn_tag[j]);
  endtask

  task automatic clear_strobes();
    s_rst = 1'b0; s_flush = 1'b0; s_alloc_en = 1'b0; s_alloc_tag = 0;
    for (int k = 0; k < NUM_WB; k++) begin
      s_wb_en[k] = 1'b0; s_wb_tag[k] = 0; s_wb_data[k] = '0;
    end
  endtask

  task automatic step();
    drive();
    q.push_back(model_out());
    @(posedge clk);
    model_edge();
    #1;
    clear_strobes();
  endtask

  initial begin
    for (int i = 0; i < ARCH_REGS; i++) arch_file[i] = $urandom;
    for (int j = 0; j < NUM_RD; j++) s_rd_tag[j] = 0;
    for (int j = 0; j < NUM_RN; j++) s_rn_tag[j] = 0;
    clear_strobes();
    s_rst = 1'b1;
    drive();
    @(posedge clk);
    model_edge();
    #1;
    clear_strobes();

    // Reset contents
    s_rd_tag[0] = 5; s_rd_tag[1] = 40; s_rn_tag[0] = 5; s_rn_tag[1] = 40;
    step();

    // Alloc 40, writeback two cycles later on port 2
    s_alloc_en = 1'b1; s_alloc_tag = 40; step();
    step();
    s_wb_en[2] = 1'b1; s_wb_tag[2] = 40; s_wb_data[2] = 32'hDEADBEEF; s_rd_tag[2] = 40;
    step();
    step();

    // Duplicate writeback tags: port 6 wins
    s_wb_en[0] = 1'b1; s_wb_tag[0] = 50; s_wb_data[0] = 32'h11;
    s_wb_en[6] = 1'b1; s_wb_tag[6] = 50; s_wb_data[6] = 32'h66;
    s_rd_tag[3] = 50;
    step();
    step();

    // Alloc and writeback on the same tag: data lands, ready stays low
    s_alloc_en = 1'b1; s_alloc_tag = 60;
    s_wb_en[1] = 1'b1; s_wb_tag[1] = 60; s_wb_data[1] = 32'h7;
    s_rn_tag[0] = 60; s_rd_tag[4] = 60;
    step();
    step();

    // Tag 0 is hardwired
    s_wb_en[4] = 1'b1; s_wb_tag[4] = 0; s_wb_data[4] = 32'h123; s_rd_tag[5] = 0;
    step();
    step();

    // Restore walk with a mid-walk writeback that must be lost
    s_alloc_en = 1'b1; s_alloc_tag = 100; s_rn_tag[1] = 100; step();
    arch_file[1] = 32'hAAAA; arch_file[31] = 32'h5555;
    s_rd_tag[6] = 1; s_rd_tag[7] = 31; s_rd_tag[8] = 77;
    s_flush = 1'b1; step();
    for (int c = 1; c <= 32; c++) begin
      if (c == 5) begin s_wb_en[0] = 1'b1; s_wb_tag[0] = 77; s_wb_data[0] = 32'hBAD0BAD0; end
      step();
    end
    step(); step();

    // Second flush on cycle 10 of a walk extends it to cycle 42
    s_flush = 1'b1; step();
    for (int c = 1; c <= 9; c++) step();
    s_flush = 1'b1; step();
    for (int c = 11; c <= 44; c++) step();

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      s_rst   = ($urandom_range(0, 499) == 0);
      s_flush = ($urandom_range(0, 59) == 0);
      if (s_flush) for (int i = 0; i < ARCH_REGS; i++) arch_file[i] = $urandom;
      s_alloc_en  = ($urandom_range(0, 2) == 0);
      s_alloc_tag = $urandom_range(0, 63);
      for (int k = 0; k < NUM_WB; k++) begin
        s_wb_en[k]   = ($urandom_range(0, 2) == 0);
        s_wb_tag[k]  = $urandom_range(0, 63);
        s_wb_data[k] = $urandom;
      end
      for (int j = 0; j < NUM_RD; j++)
        s_rd_tag[j] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NUM_PREGS-1)
                                                  : $urandom_range(0, 63);
      for (int j = 0; j < NUM_RN; j++)
        s_rn_tag[j] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NUM_PREGS-1)
                                                  : $urandom_range(0, 63);
      step();
    end

    drive();
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prf_param_restore.md
Name: prf_param_restore

Overview:
- Parametrised physical register file with a per-entry ready scoreboard.
- Provides NUM_WB writeback ports, NUM_RD issue-side read ports, and NUM_RN rename-side read ports that return data plus ready.
- On exception or mret, a multi-cycle restore walk copies the architectural file into entries 0..ARCH_REGS-1. This replaces a single-cycle bulk copy.
- Sits between rename/dispatch, the issue queues (ALU/MUL/DIV/BR/LS/CSR), and the execution-unit writeback buses.

Parameters:
- XLEN, 32, data width.
- NUM_PREGS, 256, physical entries; power of two; at least 2*ARCH_REGS.
- ARCH_REGS, 32, architectural registers; power of two.
- NUM_WB, 7, writeback ports.
- NUM_RD, 11, issue-side read ports.
- NUM_RN, 2, rename-side read ports with ready.
- Derived localparams: TAGW = clog2(NUM_PREGS); AW = clog2(ARCH_REGS).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- alloc_en  in  1  rename allocates alloc_tag; clears its ready bit
- alloc_tag  in  TAGW  allocated destination tag
- wb_en  in  NUM_WB  per-port writeback strobe
- wb_tag  in  NUM_WB*TAGW  packed writeback tags; port k at bits [k*TAGW +: TAGW]
- wb_data  in  NUM_WB*XLEN  packed writeback data
- rd_tag  in  NUM_RD*TAGW  packed issue read tags
- rd_data  out  NUM_RD*XLEN  combinational issue read data
- rn_tag  in  NUM_RN*TAGW  packed rename read tags
- rn_data  out  NUM_RN*XLEN  combinational rename read data
- rn_ready  out  NUM_RN  ready bit of rn_tag
- flush_req  in  1  exception|mret pulse; starts restore
- arch_idx  out  AW  architectural index being restored
- arch_data  in  XLEN  architectural value at arch_idx; combinational from the arch file, same cycle
- busy  out  1  restore in progress; rename and issue must stall
- restore_done  out  1  one-cycle pulse on the last restore write

Behaviour:
- Reset values:
  - entry i = i for i < ARCH_REGS; entry i = 0 otherwise.
  - All ready bits = 1.
  - State IDLE, busy = 0, restore_done = 0, arch_idx = 0.
  - rd_data, rn_data and rn_ready are combinational from the reset contents.
- Tag 0 is hardwired: writes and allocs to tag 0 are ignored; entry 0 always reads 0 after the first restore, and ready[0] is always 1.
- IDLE, per clock edge:
  - Each wb port k with wb_en[k]=1 and tag != 0 writes data and sets ready = 1.
  - Duplicate tags across wb ports in one cycle: the highest port index wins.
  - alloc_en with alloc_tag != 0 clears ready[alloc_tag].
  - Alloc on the same tag as a writeback in the same cycle: data is written, ready ends 0 (alloc wins).
- Reads:
  - Latency 0 (combinational array read).
  - A write becomes visible the cycle after the edge, unless PRF_BYPASS_EN is defined.
- State machine, IDLE -> RESTORE:
  - Triggered by flush_req=1 (reset has priority).
  - That edge sets all NUM_PREGS ready bits to 1 and idx = 0.
  - All wb and alloc are dropped on that cycle.
- RESTORE, each cycle:
  - arch_idx = idx.
  - Entry idx <= arch_data at the edge; idx 0 writes 0 regardless of arch_data.
  - idx increments.
  - wb_en and alloc_en are ignored; rd/rn ports still return current array contents.
  - Entries >= ARCH_REGS keep their stale data (ready = 1).
- RESTORE -> IDLE:
  - Occurs on the edge where idx == ARCH_REGS-1.
  - restore_done = 1 during that cycle; busy falls after that edge.
  - Total restore = ARCH_REGS cycles.
- Boundary cases:
  - flush_req during RESTORE restarts at idx 0, sets all ready bits to 1 again, and suppresses restore_done for the aborted walk.
  - reset during RESTORE returns to reset values on the next edge.
- busy = 1 in RESTORE only.

Optional Feature:
- PRF_BYPASS_EN defined, in IDLE only:
  - Each rd/rn port whose tag matches a same-cycle wb (tag != 0) returns that wb_data; the highest matching port wins.
  - rn_ready = 1 for such a tag, unless alloc_tag matches in the same cycle.
- PRF_BYPASS_EN undefined: reads return array contents only, with one cycle of write-to-read latency.
- No bypass in RESTORE in either build.

Test Plan:
- Reset -> rd_tag=5 gives rd_data=5; rd_tag=40 gives 0; rn_ready all 1.
- alloc_tag=40, then wb port 2 tag 40 data 0xDEADBEEF two cycles later:
  - rn_ready(40)=0 between.
  - Then 1, with rd_data=0xDEADBEEF (bypass build: same cycle as wb).
- Same cycle: wb port 0 and port 6 both to tag 50, data 0x11 and 0x66 -> entry 50 = 0x66.
- Same cycle: alloc_tag=60 and wb tag 60 data 0x7 -> data 0x7, ready 0.
- wb to tag 0 with data 0x123 -> rd_data(0) remains 0.
- flush_req with arch file x1=0xAAAA, x31=0x5555, entry 100 not ready:
  - busy for 32 cycles; restore_done pulses on cycle 32.
  - Entry 1=0xAAAA, entry 31=0x5555, ready[100]=1.
  - wb attempted mid-walk is lost.
  - A second flush_req at cycle 10 extends the walk to cycle 42.
